// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
package ifu_pkg;

   localparam int unsigned IFU_XLEN    = 32;
   localparam int unsigned INSTR_BYTES = 4;

   // One buffered fetch result as presented to decode
   typedef struct packed {
      logic [IFU_XLEN-1:0] pc;
      logic [IFU_XLEN-1:0] instr;
      logic                fault;
   } fetch_entry_t;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } ifu_state_e;

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous instruction buffer of fetch entries.
// Head is shown combinationally; flush dominates push and pop.
module ifu_fifo
   import ifu_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  fetch_entry_t             push_data,
   input  logic                     pop,
   output logic [$clog2(DEPTH):0]   count,
   output fetch_entry_t             head
);

   localparam int unsigned AW = $clog2(DEPTH);

   fetch_entry_t    mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [AW:0]     count_q;
   logic            pop_ok;
   logic            push_ok;

   // Out-of-range operations are ignored rather than corrupting the pointers
   assign pop_ok  = pop && (count_q != '0);
   assign push_ok = push && ((count_q != (AW+1)'(DEPTH)) || pop_ok);

   // Entry storage; stale contents past a flush are never read
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   // Pointer and occupancy update; pointers wrap naturally (DEPTH is 2^n)
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential PC generation, credit-limited imem requests,
// in-order response buffering and redirect flush with stale-response drop.
// Optional feature macro: IFU_MISALIGN_CHECK_EN (misaligned redirect target
// queues a single fault entry and halts fetch until the next redirect).
module instr_fetch_unit
   import ifu_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [XLEN-1:0]  boot_addr,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_addr,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [XLEN-1:0]  imem_req_addr,
   input  logic             imem_rsp_valid,
   input  logic [XLEN-1:0]  imem_rsp_data,
   output logic             if_valid,
   input  logic             if_ready,
   output logic [XLEN-1:0]  if_instr,
   output logic [XLEN-1:0]  if_pc,
   output logic             if_fault
);

   // Counter width holding 0..FIFO_DEPTH inclusive
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic [XLEN-1:0]  pc_q, pc_d;
   logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]    outst_q, outst_d;
   logic [CW-1:0]    drop_q, drop_d;
   logic [CW-1:0]    fifo_count;
   logic [CW:0]      credit_used;
   logic [XLEN-1:0]  redir_addr;
   logic             run;
   logic             fault_push;
   logic             req_fire;
   logic             rsp_keep;
   logic             fifo_push;
   logic             fifo_pop;
   fetch_entry_t     push_entry;
   fetch_entry_t     head;

`ifdef IFU_MISALIGN_CHECK_EN
   ifu_state_e state_q;
   logic       fault_pend_q;
   logic       misalign;

   assign redir_addr = redirect_addr;
   assign misalign   = |redirect_addr[1:0];
   assign run        = (state_q == RUN);
   assign fault_push = fault_pend_q;
   assign if_fault   = head.fault;

   // RUN/HALT control; fault entry is queued the cycle after the redirect,
   // once the flush has taken effect and all in-flight responses are dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         fault_pend_q <= 1'b0;
      end else if (redirect_valid) begin
         state_q      <= misalign ? HALT : RUN;
         fault_pend_q <= misalign;
      end else begin
         fault_pend_q <= 1'b0;
      end
   end
`else
   logic unused_misc;

   assign redir_addr  = {redirect_addr[XLEN-1:2], 2'b00};
   assign run         = 1'b1;
   assign fault_push  = 1'b0;
   assign if_fault    = 1'b0;
   assign unused_misc = ^{redirect_addr[1:0], head.fault};
`endif

   // Credit: buffered plus in-flight never exceeds the buffer size, so every
   // accepted response is guaranteed a free slot
   assign credit_used    = {1'b0, fifo_count} + {1'b0, outst_q};
   assign imem_req_valid = !rst && run && !redirect_valid &&
                           (credit_used < (CW+1)'(FIFO_DEPTH));
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign rsp_keep  = imem_rsp_valid && !redirect_valid && (drop_q == '0);
   assign fifo_push = rsp_keep || fault_push;
   assign if_valid  = (fifo_count != '0);
   assign fifo_pop  = if_valid && if_ready && !redirect_valid;

   // Select the entry written this cycle: a fault marker or a live response
   always_comb begin
      push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data, fault: 1'b0};
      if (fault_push) begin
         push_entry = '{pc: pc_q, instr: '0, fault: 1'b1};
      end
   end

   // Next-state for PC, response PC, in-flight and drop counters.
   // On redirect every response still in flight after this cycle is stale,
   // so the drop count becomes the post-cycle outstanding count
   always_comb begin
      pc_d     = pc_q;
      rsp_pc_d = rsp_pc_q;
      outst_d  = outst_q;
      drop_d   = drop_q;
      if (redirect_valid) begin
         pc_d     = redir_addr;
         rsp_pc_d = redir_addr;
         outst_d  = outst_q - CW'(imem_rsp_valid);
         drop_d   = outst_q - CW'(imem_rsp_valid);
      end else begin
         if (req_fire) begin
            pc_d = pc_q + XLEN'(INSTR_BYTES);
         end
         outst_d = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
         if (imem_rsp_valid) begin
            if (drop_q != '0) begin
               drop_d = drop_q - 1'b1;
            end else begin
               rsp_pc_d = rsp_pc_q + XLEN'(INSTR_BYTES);
            end
         end
      end
   end

   // Fetch bookkeeping registers; boot address captured while in reset
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= boot_addr;
         rsp_pc_q <= boot_addr;
         outst_q  <= '0;
         drop_q   <= '0;
      end else begin
         pc_q     <= pc_d;
         rsp_pc_q <= rsp_pc_d;
         outst_q  <= outst_d;
         drop_q   <= drop_d;
      end
   end

   ifu_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .count     (fifo_count),
      .head      (head)
   );

   assign if_instr = head.instr;
   assign if_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench with a simple in-order latency memory.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst;
   logic [31:0] boot_addr;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_fault;

   int n_checks;
   int n_fail;
   int n_fire;
   int cyc;
   int lat;
   logic [31:0] mq_addr[$];
   int          mq_due[$];

   instr_fetch_unit #(
      .XLEN       (32),
      .FIFO_DEPTH (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .boot_addr      (boot_addr),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_fault       (if_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: sample handshakes mid-cycle, advance memory model after edge
   task automatic tick();
      logic        fire;
      logic        rsp_seen;
      logic [31:0] a;
      @(negedge clk);
      fire     = imem_req_valid && imem_req_ready;
      rsp_seen = imem_rsp_valid;
      a        = imem_req_addr;
      @(posedge clk);
      #1;
      if (rsp_seen) begin
         void'(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end
      if (fire) begin
         n_fire++;
         mq_addr.push_back(a);
         mq_due.push_back(cyc + lat);
      end
      cyc++;
      if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(mq_addr[0]);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end
   endtask

   // Reset with given boot address; returns in the first cycle with rst low
   task automatic reset_dut(input logic [31:0] b);
      rst            = 1'b1;
      boot_addr      = b;
      redirect_valid = 1'b0;
      redirect_addr  = '0;
      mq_addr.delete();
      mq_due.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      tick();
      tick();
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_if_valid", 32'(if_valid), 32'd0);
      check("rst_if_fault", 32'(if_fault), 32'd0);
      rst = 1'b0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks       = 0;
      n_fail         = 0;
      n_fire         = 0;
      cyc            = 0;
      lat            = 1;
      imem_req_ready = 1'b1;
      if_ready       = 1'b1;

      // Straight-line fetch, latency 1
      reset_dut(32'h0000_1000);
      check("t1_req_valid", 32'(imem_req_valid), 32'd1);
      check("t1_req_addr0", imem_req_addr, 32'h0000_1000);
      tick();
      check("t1_ifv_c1", 32'(if_valid), 32'd0);
      check("t1_req_addr1", imem_req_addr, 32'h0000_1004);
      tick();
      for (int unsigned i = 0; i < 6; i++) begin
         check("t1_ifv", 32'(if_valid), 32'd1);
         check("t1_pc", if_pc, 32'h0000_1000 + 32'(4 * i));
         check("t1_instr", if_instr, mem_word(32'h0000_1000 + 32'(4 * i)));
         check("t1_req_addr", imem_req_addr, 32'h0000_1008 + 32'(4 * i));
         tick();
      end

      // Decode stalled: exactly FIFO_DEPTH requests, then drain in order
      if_ready = 1'b0;
      reset_dut(32'h0000_1000);
      n_fire = 0;
      repeat (10) tick();
      check("t2_fires", 32'(n_fire), 32'd4);
      check("t2_req_valid", 32'(imem_req_valid), 32'd0);
      check("t2_head_pc", if_pc, 32'h0000_1000);
      if_ready = 1'b1;
      #1;
      for (int unsigned i = 0; i < 6; i++) begin
         check("t2_ifv", 32'(if_valid), 32'd1);
         check("t2_pc", if_pc, 32'h0000_1000 + 32'(4 * i));
         if (i == 1) begin
            check("t2_resume_valid", 32'(imem_req_valid), 32'd1);
            check("t2_resume_addr", imem_req_addr, 32'h0000_1010);
         end
         tick();
      end

      // Latency 3 redirect with three fetches in flight
      lat = 3;
      reset_dut(32'h0000_1000);
      tick(); tick(); tick();
      redirect_valid = 1'b1;
      redirect_addr  = 32'h0000_2000;
      #1;
      check("t3_withdrawn", 32'(imem_req_valid), 32'd0);
      tick();
      redirect_valid = 1'b0;
      #1;
      check("t3_req_valid", 32'(imem_req_valid), 32'd1);
      check("t3_req_addr", imem_req_addr, 32'h0000_2000);
      for (int unsigned i = 0; i < 4; i++) begin
         check("t3_no_stale", 32'(if_valid), 32'd0);
         tick();
      end
      for (int unsigned i = 0; i < 3; i++) begin
         check("t3_ifv", 32'(if_valid), 32'd1);
         check("t3_pc", if_pc, 32'h0000_2000 + 32'(4 * i));
         check("t3_instr", if_instr, mem_word(32'h0000_2000 + 32'(4 * i)));
         tick();
      end

      // Redirect coinciding with a response and a pop, latency 2
      lat = 2;
      reset_dut(32'h0000_1000);
      tick(); tick(); tick(); tick();
      check("t4_pre_ifv", 32'(if_valid), 32'd1);
      check("t4_pre_pc", if_pc, 32'h0000_1004);
      redirect_valid = 1'b1;
      redirect_addr  = 32'h0000_3000;
      tick();
      redirect_valid = 1'b0;
      #1;
      check("t4_flushed", 32'(if_valid), 32'd0);
      check("t4_req_addr", imem_req_addr, 32'h0000_3000);
      tick();
      check("t4_drop_c6", 32'(if_valid), 32'd0);
      tick();
      check("t4_drop_c7", 32'(if_valid), 32'd0);
      tick();
      check("t4_ifv", 32'(if_valid), 32'd1);
      check("t4_pc", if_pc, 32'h0000_3000);
      check("t4_instr", if_instr, mem_word(32'h0000_3000));

      // Address wrap at the top of the address space
      lat = 1;
      reset_dut(32'hFFFF_FFF8);
      check("t5_addr0", imem_req_addr, 32'hFFFF_FFF8);
      tick();
      check("t5_addr1", imem_req_addr, 32'hFFFF_FFFC);
      tick();
      check("t5_addr2", imem_req_addr, 32'h0000_0000);
      check("t5_pc0", if_pc, 32'hFFFF_FFF8);
      tick();
      check("t5_addr3", imem_req_addr, 32'h0000_0004);
      check("t5_pc1", if_pc, 32'hFFFF_FFFC);
      tick();
      check("t5_pc2", if_pc, 32'h0000_0000);
      check("t5_instr2", if_instr, mem_word(32'h0000_0000));

      // Misaligned redirect target
      reset_dut(32'h0000_1000);
      tick(); tick();
      redirect_valid = 1'b1;
      redirect_addr  = 32'h0000_2002;
      tick();
      redirect_valid = 1'b0;
      #1;
`ifdef IFU_MISALIGN_CHECK_EN
      check("t6_halt_req_c3", 32'(imem_req_valid), 32'd0);
      check("t6_ifv_c3", 32'(if_valid), 32'd0);
      tick();
      check("t6_fault_ifv", 32'(if_valid), 32'd1);
      check("t6_fault_pc", if_pc, 32'h0000_2002);
      check("t6_fault_instr", if_instr, 32'h0000_0000);
      check("t6_fault_flag", 32'(if_fault), 32'd1);
      check("t6_halt_req_c4", 32'(imem_req_valid), 32'd0);
      tick();
      check("t6_single_entry", 32'(if_valid), 32'd0);
      check("t6_halt_req_c5", 32'(imem_req_valid), 32'd0);
      tick();
      check("t6_halt_req_c6", 32'(imem_req_valid), 32'd0);
      redirect_valid = 1'b1;
      redirect_addr  = 32'h0000_3000;
      tick();
      redirect_valid = 1'b0;
      #1;
      check("t6_resume_valid", 32'(imem_req_valid), 32'd1);
      check("t6_resume_addr", imem_req_addr, 32'h0000_3000);
      tick();
      tick();
      check("t6_resume_ifv", 32'(if_valid), 32'd1);
      check("t6_resume_pc", if_pc, 32'h0000_3000);
      check("t6_resume_fault", 32'(if_fault), 32'd0);
`else
      check("t6_req_valid", 32'(imem_req_valid), 32'd1);
      check("t6_aligned_addr", imem_req_addr, 32'h0000_2000);
      check("t6_ifv_c3", 32'(if_valid), 32'd0);
      tick();
      tick();
      check("t6_ifv", 32'(if_valid), 32'd1);
      check("t6_pc", if_pc, 32'h0000_2000);
      check("t6_fault", 32'(if_fault), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
